accel_dispatch_ctrl: RTL and testbench

- Parametrised dispatcher between the gp_cpu decode stage and NUM_CH side-channel crypto accelerators (hash, encrypt, decrypt, and future channels).
- Accepts start requests from decode and drives a held start level plus an index to the selected accelerator.
- Tracks per-channel busy/done, with timeout, and generates all four pipeline-register write enables plus an IdEx bubble.
- Supports blocking mode (whole front-end stalls while any accelerator runs) and non-blocking mode (stall only on issue to a busy channel).

---
 rtl/accel_dispatch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_accel_dispatch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_dispatch_ctrl.sv
// Dispatcher between decode and NUM_CH crypto accelerators: start/index hand-off, per-channel
// busy/done/timeout tracking, serialized completion reporting and pipeline enable generation.
module accel_dispatch_ctrl #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned CH_W     = 3,
  parameter int unsigned IDX_W    = 11,
  parameter bit          BLOCKING = 1'b1,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [CH_W-1:0]         req_ch,
  input  logic [IDX_W-1:0]        req_index,
  output logic                    req_ready,
  output logic [NUM_CH-1:0]       acc_start,
  output logic [NUM_CH*IDX_W-1:0] acc_index,
  input  logic [NUM_CH-1:0]       acc_done,
  output logic [NUM_CH-1:0]       busy,
  output logic                    cpl_valid,
  output logic [CH_W-1:0]         cpl_ch,
  output logic                    err_timeout,
  output logic                    err_badch,
  input  logic                    imem_stall,
  input  logic                    dmem_stall,
  input  logic                    halt,
  output logic                    ifid_wren,
  output logic                    idex_wren,
  output logic                    exmem_wren,
  output logic                    memwb_wren,
  output logic                    idex_bubble
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TimeoutEn = (TIMEOUT != 0);
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {StIdle, StRun} ch_state_e;

  ch_state_e         state_q [NUM_CH];
  logic [IDX_W-1:0]  idx_q   [NUM_CH];
  logic [CntW-1:0]   cnt_q   [NUM_CH];
  logic [NUM_CH-1:0] pend_done_q, pend_to_q;
  logic              cpl_valid_q, err_timeout_q, err_badch_q;
  logic [CH_W-1:0]   cpl_ch_q;

  logic [NUM_CH-1:0] run, accept_oh, done_ev, to_ev;
  logic [NUM_CH-1:0] all_done, all_to, pick_oh, pend_done_d, pend_to_d;
  logic              req_busy, ch_bad, any_busy, acc_stall;
  logic              pick_found, pick_is_done;
  logic [CH_W-1:0]   pick_ch;

  always_comb begin
    run       = '0;
    acc_index = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      run[k] = (state_q[k] == StRun);
      acc_index[k*IDX_W +: IDX_W] = idx_q[k];
    end
  end

  assign busy      = run;
  assign acc_start = run;

  // Acceptance always looks at registered busy, so done and re-issue never chain in one cycle.
  always_comb begin
    ch_bad   = (32'(req_ch) >= NUM_CH);
    req_busy = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (req_ch == CH_W'(k)) req_busy = run[k];
    end
    any_busy  = |run;
    req_ready = req_valid & ~req_busy & (~BLOCKING | ~any_busy) & ~halt;
    accept_oh = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      accept_oh[k] = req_ready & (req_ch == CH_W'(k));
    end
  end

  always_comb begin
    acc_stall   = (req_valid & ~req_ready) | (BLOCKING & any_busy);
    ifid_wren   = ~(imem_stall | dmem_stall | halt | acc_stall);
    idex_wren   = ~(dmem_stall | halt | acc_stall);
    exmem_wren  = ~(dmem_stall | halt);
    memwb_wren  = ~halt;
    idex_bubble = ~idex_wren & exmem_wren;
  end

  // New events merge with the backlog; the lowest channel is reported, the rest stay pending.
  always_comb begin
    done_ev = '0;
    to_ev   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      done_ev[k] = run[k] & acc_done[k];
      to_ev[k]   = TimeoutEn & run[k] & ~acc_done[k] & (cnt_q[k] == CntLast);
    end
    all_done     = pend_done_q | done_ev;
    all_to       = pend_to_q | to_ev;
    pick_found   = 1'b0;
    pick_is_done = 1'b0;
    pick_ch      = '0;
    pick_oh      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (all_done[k] | all_to[k]) begin
        pick_found   = 1'b1;
        pick_is_done = all_done[k];
        pick_ch      = CH_W'(k);
        pick_oh      = '0;
        pick_oh[k]   = 1'b1;
      end
    end
    pend_done_d = all_done & ~({NUM_CH{pick_is_done}} & pick_oh);
    pend_to_d   = all_to & ~({NUM_CH{~pick_is_done}} & pick_oh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= StIdle;
        idx_q[k]   <= '0;
        cnt_q[k]   <= '0;
      end
      pend_done_q   <= '0;
      pend_to_q     <= '0;
      cpl_valid_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_badch_q   <= 1'b0;
      cpl_ch_q      <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        case (state_q[k])
          StIdle: begin
            if (accept_oh[k]) begin
              state_q[k] <= StRun;
              idx_q[k]   <= req_index;
              cnt_q[k]   <= '0;
            end
          end
          StRun: begin
            if (done_ev[k] | to_ev[k]) begin
              state_q[k] <= StIdle;
            end else if (TimeoutEn) begin
              cnt_q[k] <= cnt_q[k] + 1'b1;
            end
          end
          default: state_q[k] <= StIdle;
        endcase
      end
      pend_done_q   <= pend_done_d;
      pend_to_q     <= pend_to_d;
      cpl_valid_q   <= pick_found & pick_is_done;
      err_timeout_q <= pick_found & ~pick_is_done;
      err_badch_q   <= req_ready & ch_bad;
      cpl_ch_q      <= pick_found ? pick_ch : ((req_ready & ch_bad) ? req_ch : '0);
    end
  end

  assign cpl_valid   = cpl_valid_q;
  assign err_timeout = err_timeout_q;
  assign err_badch   = err_badch_q;
  assign cpl_ch      = cpl_ch_q;

endmodule

// File: tb/tb_accel_dispatch_ctrl.sv
// Scoreboard bench: one blocking instance (TIMEOUT=16) and one non-blocking instance (no timeout).
module tb_accel_dispatch_ctrl;

  typedef struct packed {
    logic [1:0] kind;  // 0 done, 1 timeout, 2 bad channel
    logic [2:0] ch;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  ev_t b_q[$];
  ev_t n_q[$];
  ev_t b_e, n_e;

  logic        b_req_valid, b_req_ready, b_cpl_valid, b_err_timeout, b_err_badch;
  logic [2:0]  b_req_ch, b_acc_start, b_acc_done, b_busy, b_cpl_ch;
  logic [10:0] b_req_index;
  logic [32:0] b_acc_index;
  logic        b_imem_stall, b_dmem_stall, b_halt;
  logic        b_ifid, b_idex, b_exmem, b_memwb, b_bubble;

  logic        n_req_valid, n_req_ready, n_cpl_valid, n_err_timeout, n_err_badch;
  logic [2:0]  n_req_ch, n_acc_start, n_acc_done, n_busy, n_cpl_ch;
  logic [10:0] n_req_index;
  logic [32:0] n_acc_index;
  logic        n_imem_stall, n_dmem_stall, n_halt;
  logic        n_ifid, n_idex, n_exmem, n_memwb, n_bubble;

  accel_dispatch_ctrl #(.NUM_CH(3), .CH_W(3), .IDX_W(11), .BLOCKING(1'b1), .TIMEOUT(16)) u_blk (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ch(b_req_ch),
    .req_index(b_req_index), .req_ready(b_req_ready), .acc_start(b_acc_start),
    .acc_index(b_acc_index), .acc_done(b_acc_done), .busy(b_busy), .cpl_valid(b_cpl_valid),
    .cpl_ch(b_cpl_ch), .err_timeout(b_err_timeout), .err_badch(b_err_badch),
    .imem_stall(b_imem_stall), .dmem_stall(b_dmem_stall), .halt(b_halt),
    .ifid_wren(b_ifid), .idex_wren(b_idex), .exmem_wren(b_exmem), .memwb_wren(b_memwb),
    .idex_bubble(b_bubble)
  );

  accel_dispatch_ctrl #(.NUM_CH(3), .CH_W(3), .IDX_W(11), .BLOCKING(1'b0), .TIMEOUT(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_ch(n_req_ch),
    .req_index(n_req_index), .req_ready(n_req_ready), .acc_start(n_acc_start),
    .acc_index(n_acc_index), .acc_done(n_acc_done), .busy(n_busy), .cpl_valid(n_cpl_valid),
    .cpl_ch(n_cpl_ch), .err_timeout(n_err_timeout), .err_badch(n_err_badch),
    .imem_stall(n_imem_stall), .dmem_stall(n_dmem_stall), .halt(n_halt),
    .ifid_wren(n_ifid), .idex_wren(n_idex), .exmem_wren(n_exmem), .memwb_wren(n_memwb),
    .idex_bubble(n_bubble)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] k, input logic [2:0] c);
    ev_t e;
    e.kind = k;
    e.ch   = c;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop one expected event per reported pulse; {kind, ch, pulse count} must match.
  always @(negedge clk) begin
    if (b_cpl_valid | b_err_timeout | b_err_badch) begin
      if (b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL blk_unexpected_event: got cpl=%0b to=%0b bad=%0b ch=%0d expected none",
                 b_cpl_valid, b_err_timeout, b_err_badch, b_cpl_ch);
      end else begin
        b_e = b_q.pop_front();
        chk("blk_event",
            {57'd0, (b_cpl_valid ? 2'd0 : (b_err_timeout ? 2'd1 : 2'd2)), b_cpl_ch,
             2'($countones({b_cpl_valid, b_err_timeout, b_err_badch}))},
            {57'd0, b_e.kind, b_e.ch, 2'd1});
      end
    end
  end

  always @(negedge clk) begin
    if (n_cpl_valid | n_err_timeout | n_err_badch) begin
      if (n_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL nb_unexpected_event: got cpl=%0b to=%0b bad=%0b ch=%0d expected none",
                 n_cpl_valid, n_err_timeout, n_err_badch, n_cpl_ch);
      end else begin
        n_e = n_q.pop_front();
        chk("nb_event",
            {57'd0, (n_cpl_valid ? 2'd0 : (n_err_timeout ? 2'd1 : 2'd2)), n_cpl_ch,
             2'($countones({n_cpl_valid, n_err_timeout, n_err_badch}))},
            {57'd0, n_e.kind, n_e.ch, 2'd1});
      end
    end
  end

  initial begin
    {b_req_valid, b_req_ch, b_req_index, b_acc_done, b_imem_stall, b_dmem_stall, b_halt} = '0;
    {n_req_valid, n_req_ch, n_req_index, n_acc_done, n_imem_stall, n_dmem_stall, n_halt} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_blk_start", b_acc_start, 0);
    chk("rst_blk_busy", b_busy, 0);
    chk("rst_blk_index", b_acc_index, 0);
    chk("rst_blk_flags", {b_cpl_valid, b_err_timeout, b_err_badch, b_cpl_ch}, 0);
    chk("rst_nb_state", {n_acc_start, n_busy, n_acc_index}, 0);
    chk("rst_nb_flags", {n_cpl_valid, n_err_timeout, n_err_badch, n_cpl_ch}, 0);
    chk("idle_blk_wren", {b_ifid, b_idex, b_exmem, b_memwb, b_bubble}, 5'b11110);
    rst_n = 1'b1;

    // Blocking: ch1 idx 0x2A5, done in the 10th running cycle.
    tick();
    b_req_valid = 1'b1; b_req_ch = 3'd1; b_req_index = 11'h2A5;
    b_q.push_back(mk(2'd0, 3'd1));
    #1;
    chk("blk_accept_ready", b_req_ready, 1);
    chk("blk_accept_wren", {b_ifid, b_idex, b_exmem, b_memwb, b_bubble}, 5'b11110);
    tick();
    b_req_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) b_acc_done = 3'b010;
      #1;
      chk("blk_run_start", b_acc_start, 3'b010);
      chk("blk_run_wren", {b_ifid, b_idex, b_exmem, b_memwb, b_bubble}, 5'b00111);
      if (i == 1) chk("blk_run_index", b_acc_index[11 +: 11], 11'h2A5);
      if (i == 5) begin
        b_req_valid = 1'b1; b_req_ch = 3'd0;
        #1;
        chk("blk_other_ch_refused", b_req_ready, 0);
        b_req_valid = 1'b0;
      end
      if (i < 10) tick();
    end
    tick();
    b_acc_done = 3'b000;
    #1;
    chk("blk_done_start", b_acc_start, 0);
    chk("blk_done_wren", {b_ifid, b_idex, b_exmem, b_memwb, b_bubble}, 5'b11110);

    // Timeout: ch2 runs 16 cycles, then a late done is ignored.
    tick();
    b_req_valid = 1'b1; b_req_ch = 3'd2; b_req_index = 11'h155;
    b_q.push_back(mk(2'd1, 3'd2));
    #1;
    chk("to_accept_ready", b_req_ready, 1);
    tick();
    b_req_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk("to_run_start", b_acc_start, 3'b100);
      tick();
    end
    b_acc_done = 3'b100;
    #1;
    chk("to_expired_start", b_acc_start, 0);
    tick();
    b_acc_done = 3'b000;
    #1;
    chk("to_late_done_busy", b_busy, 0);

    // Illegal channel with dmem_stall, then halt.
    tick();
    b_req_valid = 1'b1; b_req_ch = 3'd5; b_dmem_stall = 1'b1;
    b_q.push_back(mk(2'd2, 3'd5));
    #1;
    chk("badch_ready", b_req_ready, 1);
    chk("dmem_stall_wren", {b_ifid, b_idex, b_exmem, b_memwb, b_bubble}, 5'b00010);
    tick();
    b_req_valid = 1'b0; b_dmem_stall = 1'b0;
    #1;
    chk("badch_no_start", b_acc_start, 0);
    b_req_valid = 1'b1; b_req_ch = 3'd0; b_halt = 1'b1;
    #1;
    chk("halt_ready", b_req_ready, 0);
    chk("halt_wren", {b_ifid, b_idex, b_exmem, b_memwb, b_bubble}, 5'b00000);
    tick();
    b_req_valid = 1'b0; b_halt = 1'b0;
    #1;
    chk("halt_no_start", b_busy, 0);

    // Reset while ch1 runs, then a clean restart.
    tick();
    b_req_valid = 1'b1; b_req_ch = 3'd1; b_req_index = 11'h3C3;
    tick();
    b_req_valid = 1'b0;
    tick();
    #1;
    chk("mid_run_busy", b_busy, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", {b_acc_start, b_busy, b_acc_index}, 0);
    chk("async_rst_flags", {b_cpl_valid, b_err_timeout, b_err_badch, b_cpl_ch}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    b_req_valid = 1'b1; b_req_ch = 3'd1; b_req_index = 11'h0F0;
    b_q.push_back(mk(2'd0, 3'd1));
    #1;
    chk("restart_ready", b_req_ready, 1);
    tick();
    b_req_valid = 1'b0;
    b_acc_done = 3'b010;
    #1;
    chk("restart_start", b_acc_start, 3'b010);
    chk("restart_index", b_acc_index[11 +: 11], 11'h0F0);
    tick();
    b_acc_done = 3'b000;
    #1;
    chk("restart_done_busy", b_busy, 0);

    // Non-blocking: ch0 then ch2 back to back, simultaneous done.
    tick();
    n_req_valid = 1'b1; n_req_ch = 3'd0; n_req_index = 11'h011;
    n_q.push_back(mk(2'd0, 3'd0));
    #1;
    chk("nb_ch0_ready", n_req_ready, 1);
    tick();
    n_req_ch = 3'd2; n_req_index = 11'h022;
    n_q.push_back(mk(2'd0, 3'd2));
    #1;
    chk("nb_ch2_ready", n_req_ready, 1);
    chk("nb_ch2_wren", {n_ifid, n_idex, n_exmem, n_memwb, n_bubble}, 5'b11110);
    tick();
    n_req_valid = 1'b0;
    n_acc_done = 3'b101;
    #1;
    chk("nb_both_busy", n_busy, 3'b101);
    chk("nb_both_index", {n_acc_index[22 +: 11], n_acc_index[0 +: 11]}, {11'h022, 11'h011});
    tick();
    n_acc_done = 3'b000;
    #1;
    chk("nb_both_done_busy", n_busy, 0);
    tick();

    // Non-blocking: second request to busy ch0 waits until after done.
    tick();
    n_req_valid = 1'b1; n_req_ch = 3'd0; n_req_index = 11'h0AA;
    n_q.push_back(mk(2'd0, 3'd0));
    #1;
    chk("nb_first_ready", n_req_ready, 1);
    tick();
    n_req_index = 11'h0BB;
    n_q.push_back(mk(2'd0, 3'd0));
    #1;
    chk("nb_conflict_ready", n_req_ready, 0);
    chk("nb_conflict_wren", {n_ifid, n_idex, n_exmem, n_memwb, n_bubble}, 5'b00111);
    tick();
    n_acc_done = 3'b001;
    #1;
    chk("nb_done_cycle_ready", n_req_ready, 0);
    tick();
    n_acc_done = 3'b000;
    #1;
    chk("nb_after_done_ready", n_req_ready, 1);
    chk("nb_after_done_busy", n_busy, 0);
    chk("nb_after_done_wren", {n_ifid, n_idex, n_exmem, n_memwb, n_bubble}, 5'b11110);
    tick();
    n_req_valid = 1'b0;
    n_acc_done = 3'b001;
    #1;
    chk("nb_second_busy", n_busy, 3'b001);
    chk("nb_second_index", n_acc_index[0 +: 11], 11'h0BB);
    tick();
    n_acc_done = 3'b000;
    #1;
    chk("nb_second_done_busy", n_busy, 0);

    repeat (3) tick();
    chk("blk_events_drained", 64'(b_q.size()), 0);
    chk("nb_events_drained", 64'(n_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
